// File: rtl/moravec_score_unit.sv
// moravec_score_unit
// Streams one window of WIN pixel beats (a centre pixel plus NDIR shifted
// target pixels per beat), accumulates a sum of squared differences per
// direction, then scans the directions for the minimum and flags a corner
// when that minimum strictly exceeds the threshold sampled on the last beat.
//
// Ports:
//   clk         clock, all state on rising edge
//   rst         asynchronous, active-high reset
//   in_valid    input beat valid
//   in_ready    block accepts a beat this cycle
//   in_center   centre pixel
//   in_target   target pixel for direction d at [d*PIX_W +: PIX_W]
//   threshold   corner threshold, sampled on the last accepted beat
//   out_valid   result valid (held until out_ready)
//   out_ready   downstream accepts result
//   out_score   minimum directional SSD
//   out_dir     index of the minimum direction (lowest index on ties)
//   out_corner  out_score > sampled threshold
//
// Optional build macro: MORAVEC_HALF_RATE_EN -- accept beats only on
// alternate cycles while accumulating (legacy half-rate pipeline).

module moravec_score_unit #(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned NDIR  = 4,
  parameter int unsigned WIN   = 9,
  localparam int unsigned SCORE_W = 2 * PIX_W + $clog2(WIN + 1),
  localparam int unsigned DIR_W   = ($clog2(NDIR) > 1) ? $clog2(NDIR) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [PIX_W-1:0]        in_center,
  input  logic [NDIR*PIX_W-1:0]   in_target,
  input  logic [SCORE_W-1:0]      threshold,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SCORE_W-1:0]      out_score,
  output logic [DIR_W-1:0]        out_dir,
  output logic                    out_corner
);

  localparam int unsigned CNT_W = ($clog2(WIN) > 1) ? $clog2(WIN) : 1;

  localparam logic [1:0] ST_ACCUM  = 2'd0;
  localparam logic [1:0] ST_MINSEL = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  logic [1:0]         state_q;
  logic [1:0]         state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [DIR_W-1:0]   sidx_q;
  logic [SCORE_W-1:0] acc_q [NDIR];
  logic [SCORE_W-1:0] sq_c  [NDIR];
  logic [SCORE_W-1:0] thr_q;
  logic [SCORE_W-1:0] min_q;
  logic [DIR_W-1:0]   mdir_q;
  logic [SCORE_W-1:0] cand_c;
  logic [SCORE_W-1:0] min_c;
  logic [DIR_W-1:0]   mdir_c;
  logic               take_c;
  logic               accept_c;
  logic               last_beat_c;
  logic               scan_done_c;
  logic               rate_ok_c;

  // True unsigned absolute difference, never wraps.
  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a,
                                                input logic [PIX_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

`ifdef MORAVEC_HALF_RATE_EN
  logic toggle_q;

  // Phase toggle: beats are only taken when it is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) toggle_q <= 1'b1;
    else     toggle_q <= ~toggle_q;
  end

  assign rate_ok_c = toggle_q;
`else
  assign rate_ok_c = 1'b1;
`endif

  // Combinational ready so it reads 1 in the very first cycle after reset.
  assign in_ready    = (state_q == ST_ACCUM) && !rst && rate_ok_c;
  assign accept_c    = in_valid && in_ready;
  assign last_beat_c = (cnt_q == CNT_W'(WIN - 1));
  assign scan_done_c = (sidx_q == DIR_W'(NDIR - 1));

  // Per-direction squared difference of the current beat.
  always_comb begin
    for (int d = 0; d < NDIR; d++) begin
      sq_c[d] = SCORE_W'(abs_diff(in_target[d*PIX_W +: PIX_W], in_center))
              * SCORE_W'(abs_diff(in_target[d*PIX_W +: PIX_W], in_center));
    end
  end

  // Running minimum; replace only on strictly smaller so ties keep the lower index.
  always_comb begin
    cand_c = acc_q[sidx_q];
    take_c = (sidx_q == '0) || (cand_c < min_q);
    min_c  = take_c ? cand_c : min_q;
    mdir_c = take_c ? sidx_q : mdir_q;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACCUM:  if (accept_c && last_beat_c) state_d = ST_MINSEL;
      ST_MINSEL: if (scan_done_c)             state_d = ST_HOLD;
      ST_HOLD:   if (out_ready)               state_d = ST_ACCUM;
      default:                                state_d = ST_ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_ACCUM;
    else     state_q <= state_d;
  end

  // Accumulators, scan registers and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < NDIR; d++) acc_q[d] <= '0;
      cnt_q      <= '0;
      sidx_q     <= '0;
      thr_q      <= '0;
      min_q      <= '0;
      mdir_q     <= '0;
      out_valid  <= 1'b0;
      out_score  <= '0;
      out_dir    <= '0;
      out_corner <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (accept_c) begin
            for (int d = 0; d < NDIR; d++) acc_q[d] <= acc_q[d] + sq_c[d];
            if (last_beat_c) begin
              thr_q  <= threshold;
              sidx_q <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_MINSEL: begin
          min_q  <= min_c;
          mdir_q <= mdir_c;
          sidx_q <= sidx_q + DIR_W'(1);
          if (scan_done_c) begin
            out_score  <= min_c;
            out_dir    <= mdir_c;
            out_corner <= (min_c > thr_q);
            out_valid  <= 1'b1;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            for (int d = 0; d < NDIR; d++) acc_q[d] <= '0;
            cnt_q     <= '0;
            out_valid <= 1'b0;
          end
        end
        default: begin
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/moravec_score_unit.md
# moravec_score_unit

Parametrised Moravec corner-score engine for the Harris/Moravec front end. It streams one window of pixel beats, each carrying a centre pixel and NDIR shifted target pixels, and accumulates a sum of squared differences per shift direction. At window end it selects the minimum over directions, reports the winning direction, and flags a corner against a runtime threshold. It generalises the single-comparison Moravec flip-flop to configurable pixel width, window size and direction count, with valid/ready handshakes on both sides.

## Interface
- PIX_W, 8, pixel width in bits
- NDIR, 4, number of shift directions (≥2)
- WIN, 9, pixel beats per window (≥2)
- SCORE_W (localparam), 2*PIX_W+$clog2(WIN+1), accumulator/score width
- DIR_W (localparam), max(1,$clog2(NDIR)), direction index width

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block accepts beat this cycle
- in_center  in  PIX_W  centre pixel
- in_target  in  NDIR*PIX_W  target pixel for direction d at [d*PIX_W +: PIX_W]
- threshold  in  SCORE_W  corner threshold, sampled on the last accepted beat of a window
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_score  out  SCORE_W  minimum directional SSD
- out_dir  out  DIR_W  index of the minimum direction
- out_corner  out  1  out_score > sampled threshold (strict)

## Operation
- Beat accepted when in_valid && in_ready at a rising edge.
- Per direction: diff = |target_d − center| (true unsigned absolute difference, no wrap); acc[d] += diff*diff at full SCORE_W width; no saturation is needed because the width covers WIN*(2^PIX_W−1)^2.
- Beat counter runs 0..WIN−1. The accept at count WIN−1 latches threshold and moves to MINSEL.
- States:
  - ACCUM: in_ready=1. Moves to MINSEL on the last beat.
  - MINSEL: in_ready=0. Scans one direction per cycle, d=0..NDIR−1, keeping a running minimum. Replacement only on strictly smaller, so ties resolve to the lowest index. After NDIR cycles it registers score, dir and corner and moves to HOLD.
  - HOLD: out_valid=1, in_ready=0. On out_ready it clears accumulators and the beat counter and returns to ACCUM.
- Outputs hold stable throughout HOLD regardless of input activity.

## Timing
- Reset values: state ACCUM, accumulators 0, counter 0, out_valid 0, out_score 0, out_dir 0, out_corner 0. in_ready is 0 while rst is high and 1 in the first cycle after deassertion.
- Latency: out_valid rises NDIR cycles after the edge that accepts the last beat.
- Throughput: at minimum WIN+NDIR+1 cycles per window when in_valid and out_ready are held high. in_ready returns to 1 in the cycle after the output handshake.
- Reset mid-window or mid-HOLD: partial sums are discarded and out_valid drops immediately (asynchronous). No result is emitted for the interrupted window.
- in_valid asserted outside ACCUM: the beat is not consumed, and the source must hold it.
- threshold changes after sampling do not affect the pending result.

## Configuration
- MORAVEC_HALF_RATE_EN defined: a toggle register (reset 1, inverts every cycle) gates in_ready in ACCUM, so beats are accepted only on alternate cycles, matching the legacy half-rate flip pipeline. MINSEL and HOLD are unaffected.
- Undefined: in_ready=1 on every ACCUM cycle.

## Test plan
- Defaults, center=100 every beat, targets {110,95,130,80}, threshold=200 -> score=225, dir=1, corner=1. Repeat with threshold=225 -> corner=0.
- Tie: targets {110,105,130,95}, center=100 -> dirs 1 and 3 both give 225; required dir=1. Also checks abs diff when target<center.
- Extreme: center=0, all targets 255 -> score=585225, no overflow, dir=0.
- Backpressure: out_ready low for 10 cycles after out_valid -> outputs stable, in_ready=0, offered beats unconsumed. Release -> single handshake, next window computes independently.
- rst pulse after 4 accepted beats -> out_valid stays 0. The next 9 beats give a result from those 9 only.
- MORAVEC_HALF_RATE_EN, in_valid held high -> beats accepted every other cycle, 9 beats span 17 cycles, result identical to the non-macro run.
